page_read_unpacker: RTL and testbench

- Consumer end of the page write interface. Accepts the paired 128-bit page write words (val1 and val2), each carrying four 32-bit complex samples.
- Buffers them in a small FIFO and replays them lane by lane as top/bottom 32-bit butterfly operand pairs, with a valid/ready handshake on both sides.
- Sits between one FFT page stage's write port and the butterfly inputs of the next stage.
- Flags the last pair of each frame.

---
 rtl/page_read_unpacker.sv | 90 +++++++++
 tb/tb_page_read_unpacker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/page_read_unpacker.sv
// rtl/page_read_unpacker.sv - buffers paired page-write words and replays them lane by lane as butterfly operands
module page_read_unpacker #(
  parameter int DEPTH           = 4,
  parameter int WORDS_PER_FRAME = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [127:0]           i_write_val1,
  input  logic [127:0]           i_write_val2,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [31:0]            o_butterfly_top,
  output logic [31:0]            o_butterfly_bottom,
  output logic [1:0]             o_lane,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_last,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [FW-1:0] LAST_WORD = FW'(WORDS_PER_FRAME - 1);

  logic [255:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    lane_q, lane_d;
  logic [FW-1:0] word_idx_q, word_idx_d;
  logic          push, xfer, pop;
  logic [255:0]  head;

  assign o_ready = !reset && (count_q < FULL_CNT);
  assign o_valid = (count_q != '0);
  assign o_lane  = lane_q;
  assign o_count = count_q;
  assign o_last  = o_valid && (lane_q == 2'd3) && (word_idx_q == LAST_WORD);

  assign push = i_valid && o_ready;
  assign xfer = o_valid && i_ready;
  assign pop  = xfer && (lane_q == 2'd3);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    lane_d     = lane_q;
    word_idx_d = word_idx_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (xfer) lane_d = lane_q + 2'd1;
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      word_idx_d = (word_idx_q == LAST_WORD) ? '0 : word_idx_q + FW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lane_q     <= '0;
      word_idx_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lane_q     <= lane_d;
      word_idx_q <= word_idx_d;
    end
  end

  // Storage is not reset; push already excludes reset through o_ready.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {i_write_val2, i_write_val1};
  end

  assign head               = mem_q[rd_ptr_q];
  assign o_butterfly_top    = head[{1'b0, lane_q, 5'd0} +: 32];
  assign o_butterfly_bottom = head[{1'b1, lane_q, 5'd0} +: 32];

endmodule

// File: tb/tb_page_read_unpacker.sv
// tb/tb_page_read_unpacker.sv - self-checking bench for page_read_unpacker
module tb_page_read_unpacker;
  localparam int DEPTH = 4;
  localparam int WPF   = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] val1, val2;
  logic         i_valid, i_ready;
  logic         o_ready, o_valid, o_last;
  logic [31:0]  o_top, o_bot;
  logic [1:0]   o_lane;
  logic [2:0]   o_count;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of buffered word pairs, current lane, words completed in frame.
  logic [255:0] mq[$];
  int           mlane = 0;
  int           mword = 0;

  typedef struct {
    logic         rst, v;
    logic [127:0] a, b;
    logic         rdy;
    logic         ev;
    logic [1:0]   elane;
    logic [31:0]  etop, ebot;
    logic [2:0]   ecount;
    logic         elast, eready, chkd;
  } vec_t;

  vec_t tv[7];

  page_read_unpacker #(.DEPTH(DEPTH), .WORDS_PER_FRAME(WPF)) dut (
    .clock(clock), .reset(reset),
    .i_write_val1(val1), .i_write_val2(val2), .i_valid(i_valid), .o_ready(o_ready),
    .o_butterfly_top(o_top), .o_butterfly_bottom(o_bot), .o_lane(o_lane),
    .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last), .o_count(o_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [127:0] a, input logic [127:0] b,
                       input logic rdy);
    reset = r; i_valid = v; val1 = a; val2 = b; i_ready = rdy;
    #1;
  endtask

  task automatic model_check();
    logic [255:0] h;
    logic         ev;
    ev = (mq.size() != 0);
    chk("m_valid", 64'(o_valid), 64'(ev));
    chk("m_count", 64'(o_count), 64'(mq.size()));
    chk("m_ready", 64'(o_ready), 64'(!reset && mq.size() < DEPTH));
    chk("m_lane",  64'(o_lane),  64'(mlane));
    chk("m_last",  64'(o_last),  64'(ev && mlane == 3 && mword == WPF - 1));
    if (ev) begin
      h = mq[0];
      chk("m_top", 64'(o_top), 64'(h[mlane*32 +: 32]));
      chk("m_bot", 64'(o_bot), 64'(h[128 + mlane*32 +: 32]));
    end
  endtask

  task automatic tick();
    logic acc;
    @(posedge clock);
    if (reset) begin
      mq.delete(); mlane = 0; mword = 0;
    end else begin
      acc = i_valid && (mq.size() < DEPTH);
      if (mq.size() != 0 && i_ready) begin
        if (mlane == 3) begin
          void'(mq.pop_front());
          mlane = 0;
          mword = (mword + 1) % WPF;
        end else mlane++;
      end
      if (acc) mq.push_back({val2, val1});
    end
    #1;
  endtask

  function automatic logic [127:0] wordn(input logic [31:0] base, input int n);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) w[k*32 +: 32] = base + 32'(n*16 + k);
    return w;
  endfunction

  function automatic logic [127:0] tagw(input int n, input logic bot);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) w[k*32 +: 32] = (bot ? 32'h8000_0000 : 32'h0) | 32'(n*4 + k);
    return w;
  endfunction

  initial begin
    logic [127:0] v1, v2;
    logic         v, r;
    int           np, nt;

    drive(1'b1, 1'b0, '0, '0, 1'b0);
    repeat (3) tick();

    // Single word through an empty FIFO with the consumer always ready.
    v1 = 128'h00000003_00000002_00000001_00000000;
    v2 = 128'h00000013_00000012_00000011_00000010;
    tv[0] = '{1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0,  3'd0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b1, v1, v2, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0,  3'd0, 1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h10, 3'd1, 1'b0, 1'b1, 1'b1};
    tv[3] = '{1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 2'd1, 32'h1, 32'h11, 3'd1, 1'b0, 1'b1, 1'b1};
    tv[4] = '{1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 2'd2, 32'h2, 32'h12, 3'd1, 1'b0, 1'b1, 1'b1};
    tv[5] = '{1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 2'd3, 32'h3, 32'h13, 3'd1, 1'b0, 1'b1, 1'b1};
    tv[6] = '{1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0,  3'd0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(tv[i].rst, tv[i].v, tv[i].a, tv[i].b, tv[i].rdy);
      chk("t1_valid", 64'(o_valid), 64'(tv[i].ev));
      chk("t1_count", 64'(o_count), 64'(tv[i].ecount));
      chk("t1_ready", 64'(o_ready), 64'(tv[i].eready));
      chk("t1_lane",  64'(o_lane),  64'(tv[i].elane));
      chk("t1_last",  64'(o_last),  64'(tv[i].elast));
      if (tv[i].chkd) begin
        chk("t1_top", 64'(o_top), 64'(tv[i].etop));
        chk("t1_bot", 64'(o_bot), 64'(tv[i].ebot));
      end
      model_check();
      tick();
    end

    // Backpressure: five pushes, only four fit; a fresh word offered while full is dropped.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, wordn(32'hA000_0000, i), wordn(32'hB000_0000, i), 1'b0);
      chk("t2_ready", 64'(o_ready), 64'(i < 4));
      model_check();
      tick();
    end
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b1, wordn(32'hA000_0000, 9), wordn(32'hB000_0000, 9), 1'b0);
      chk("t2_full_count", 64'(o_count), 64'd4);
      chk("t2_full_ready", 64'(o_ready), 64'd0);
      chk("t2_hold_top",   64'(o_top),   64'h A000_0000);
      chk("t2_hold_bot",   64'(o_bot),   64'h B000_0000);
      chk("t2_hold_lane",  64'(o_lane),  64'd0);
      model_check();
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      chk("t2_drain_lane",  64'(o_lane),  64'(c));
      chk("t2_drain_ready", 64'(o_ready), 64'd0);
      model_check();
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    chk("t2_reopen_ready", 64'(o_ready), 64'd1);
    chk("t2_reopen_count", 64'(o_count), 64'd3);

    // Simultaneous push and final-lane pop at count 2.
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      model_check();
      tick();
    end
    drive(1'b0, 1'b1, wordn(32'hA000_0000, 5), wordn(32'hB000_0000, 5), 1'b1);
    chk("t3_lane3",  64'(o_lane),  64'd3);
    chk("t3_count2", 64'(o_count), 64'd2);
    model_check();
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("t3_count_after", 64'(o_count), 64'd2);
    chk("t3_head_top",    64'(o_top),   64'h A000_0030);
    chk("t3_head_bot",    64'(o_bot),   64'h B000_0030);
    chk("t3_head_lane",   64'(o_lane),  64'd0);
    model_check();

    // Reset mid-word with count 3 and lane 2; reset also overrides a push/pop.
    drive(1'b0, 1'b1, wordn(32'hA000_0000, 6), wordn(32'hB000_0000, 6), 1'b1);
    model_check();
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    model_check();
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("t5_pre_count", 64'(o_count), 64'd3);
    chk("t5_pre_lane",  64'(o_lane),  64'd2);
    drive(1'b1, 1'b1, wordn(32'hA000_0000, 7), wordn(32'hB000_0000, 7), 1'b1);
    chk("t5_rst_ready", 64'(o_ready), 64'd0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("t5_valid", 64'(o_valid), 64'd0);
    chk("t5_count", 64'(o_count), 64'd0);
    chk("t5_lane",  64'(o_lane),  64'd0);
    chk("t5_last",  64'(o_last),  64'd0);
    chk("t5_ready", 64'(o_ready), 64'd1);
    model_check();

    // Two frames of tagged words with random handshakes; frame position restarts from the reset above.
    np = 0;
    nt = 0;
    for (int cyc = 0; cyc < 3000 && nt < 64; cyc++) begin
      v = (np < 16) && ($urandom % 4 != 0);
      r = ($urandom % 3 != 0);
      drive(1'b0, v, tagw(np, 1'b0), tagw(np, 1'b1), r);
      model_check();
      if (o_valid && r) begin
        chk("t4_top",  64'(o_top),  64'(nt));
        chk("t4_bot",  64'(o_bot),  64'(32'h8000_0000 | 32'(nt)));
        chk("t4_lane", 64'(o_lane), 64'(nt % 4));
        chk("t4_last", 64'(o_last), 64'(nt % 32 == 31));
        nt++;
      end
      if (v && o_ready) np++;
      tick();
    end
    chk("t4_transfers", 64'(nt), 64'd64);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    chk("t4_empty_valid", 64'(o_valid), 64'd0);
    chk("t4_empty_count", 64'(o_count), 64'd0);
    model_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
